// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store port: RV32 load/store funct3 codes
// and the port controller state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_if.sv
// Core request/response handshake plus the data-memory port, bundled so the
// LSU and its environment share one connection point.
interface lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;

    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_cen;
    logic [31:0] mem_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  rsp_ready, mem_data,
        output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err,
        output mem_addr, mem_wmask, mem_wdata, mem_cen
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output rsp_ready, mem_data,
        input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err,
        input  mem_addr, mem_wmask, mem_wdata, mem_cen
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational datapath of the LSU: store lane placement and byte mask,
// request legality checks, and load byte/half extraction with extension.
import lsu_pkg::*;

module lsu_align #(
    parameter int ADDR_BITS = 16
) (
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_mem_data,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic        o_err,
    output logic [31:0] o_ld_data
);

    logic        w_illegal;
    logic        w_misalign;
    logic        w_oor;
    logic [31:0] w_shifted;

    assign w_oor = |(i_addr >> ADDR_BITS);
    assign o_err = w_illegal | w_misalign | w_oor;

    // Store lanes replicate the datum so the mask alone selects the bytes.
    always_comb begin
        o_wmask    = 4'b0000;
        o_wdata    = 32'd0;
        w_illegal  = 1'b0;
        w_misalign = 1'b0;
        case (i_funct3)
            F3_B: begin
                o_wmask = 4'b0001 << i_addr[1:0];
                o_wdata = {4{i_wdata[7:0]}};
            end
            F3_H: begin
                o_wmask    = 4'b0011 << {i_addr[1], 1'b0};
                o_wdata    = {2{i_wdata[15:0]}};
                w_misalign = i_addr[0];
            end
            F3_W: begin
                o_wmask    = 4'b1111;
                o_wdata    = i_wdata;
                w_misalign = |i_addr[1:0];
            end
            F3_BU:   w_illegal = i_we;
            F3_HU: begin
                w_illegal  = i_we;
                w_misalign = i_addr[0];
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_shifted = i_mem_data >> {i_ld_off, 3'b000};

    // Load extension uses the funct3/offset latched when the load was accepted.
    always_comb begin
        o_ld_data = 32'd0;
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_ld_data = w_shifted;
            F3_BU:   o_ld_data = {24'd0, w_shifted[7:0]};
            F3_HU:   o_ld_data = {16'd0, w_shifted[15:0]};
            default: o_ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_port.sv
// Load/store unit in front of one synchronous data-RAM port: one access
// outstanding, registered response, back-to-back accept from RESP.
import lsu_pkg::*;

module lsu_port #(
    parameter int ADDR_BITS = 16
) (
    input  logic  clk,
    input  logic  reset,
    lsu_if.slave  bus
);

    lsu_state_t  r_state;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [4:0]  r_rd;
    logic [31:0] r_data;
    logic        r_valid;
    logic        r_err;

    logic        w_fire;
    logic        w_err;
    logic        w_access;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_data;

    lsu_align #(.ADDR_BITS(ADDR_BITS)) u_align (
        .i_we        (bus.req_we),
        .i_funct3    (bus.req_funct3),
        .i_addr      (bus.req_addr),
        .i_wdata     (bus.req_wdata),
        .i_ld_funct3 (r_f3),
        .i_ld_off    (r_off),
        .i_mem_data  (bus.mem_data),
        .o_wmask     (w_wmask),
        .o_wdata     (w_wdata),
        .o_err       (w_err),
        .o_ld_data   (w_ld_data)
    );

    assign bus.req_ready = (r_state == IDLE) || ((r_state == RESP) && bus.rsp_ready);
    assign w_fire        = bus.req_valid && bus.req_ready;
    assign w_access      = w_fire && !w_err;

    // Memory strobes exist only in the accept cycle of a legal request.
    assign bus.mem_cen   = w_access;
    assign bus.mem_addr  = w_access ? {bus.req_addr[31:2], 2'b00} : 32'd0;
    assign bus.mem_wmask = (w_access && bus.req_we) ? w_wmask : 4'b0000;
    assign bus.mem_wdata = (w_access && bus.req_we) ? w_wdata : 32'd0;

    assign bus.rsp_valid = r_valid;
    assign bus.rsp_data  = r_data;
    assign bus.rsp_rd    = r_rd;
    assign bus.rsp_err   = r_err;

    // Controller: accept, wait one cycle for read data, then hold the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_f3    <= 3'd0;
            r_off   <= 2'd0;
            r_rd    <= 5'd0;
            r_data  <= 32'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_fire) begin
            r_f3   <= bus.req_funct3;
            r_off  <= bus.req_addr[1:0];
            r_rd   <= bus.req_rd;
            r_err  <= w_err;
            r_data <= 32'd0;
            if (w_err || bus.req_we) begin
                r_valid <= 1'b1;
                r_state <= RESP;
            end else begin
                r_valid <= 1'b0;
                r_state <= LOAD;
            end
        end else begin
            case (r_state)
                LOAD: begin
                    r_data  <= w_ld_data;
                    r_valid <= 1'b1;
                    r_state <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_valid <= 1'b0;
                        r_err   <= 1'b0;
                        r_data  <= 32'd0;
                        r_state <= IDLE;
                    end
                end
                IDLE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
